// File: rtl/gray_count_arbiter_if.sv
// rtl/gray_count_arbiter_if.sv - request/grant and Gray counter bundle for gray_count_arbiter
interface gray_count_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] gray;
  logic [1:0]       done;
  logic             busy;

  // Requesters drive req and run lengths and observe grant/count/status.
  modport master (
    output req, len0, len1,
    input  gnt, gray, done, busy
  );

  // The arbiter consumes requests and produces grant/count/status.
  modport slave (
    input  req, len0, len1,
    output gnt, gray, done, busy
  );
endinterface

// File: rtl/gray_count_arbiter.sv
// rtl/gray_count_arbiter.sv - two-requester arbiter driving a shared Gray run counter (option: GRAY_ARB_FIXED_PRIO_EN)
module gray_count_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  gray_count_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] len_q, len_d;
  // Index of the most recent grantee; while in RUN/DONE it is the current owner.
  logic             last_owner_q, last_owner_d;
  logic             sel;
  logic [WIDTH-1:0] bin_inc;

  assign bin_inc = bin_q + {{(WIDTH-1){1'b0}}, 1'b1};

  // Pick which requester wins when the FSM samples requests in IDLE.
  always_comb begin
`ifdef GRAY_ARB_FIXED_PRIO_EN
    sel = ~bus.req[0];
`else
    if (bus.req == 2'b11) begin
      sel = ~last_owner_q;
    end else begin
      sel = bus.req[1];
    end
`endif
  end

  // Next-state and next-output logic; abort is tested before terminal count.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = 2'b00;
    bin_d        = bin_q;
    gray_d       = gray_q;
    len_d        = len_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          state_d      = RUN;
          gnt_d        = sel ? 2'b10 : 2'b01;
          bin_d        = '0;
          gray_d       = '0;
          len_d        = sel ? bus.len1 : bus.len0;
          last_owner_d = sel;
        end
      end
      RUN: begin
        if (!bus.req[last_owner_q]) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end else if (bin_q == len_q) begin
          state_d = DONE;
          gnt_d   = 2'b00;
          done_d  = last_owner_q ? 2'b10 : 2'b01;
        end else begin
          bin_d  = bin_inc;
          gray_d = bin_inc ^ (bin_inc >> 1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State and output registers; clear forces the idle/reset values at once.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      bin_q        <= '0;
      gray_q       <= '0;
      len_q        <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      bin_q        <= bin_d;
      gray_q       <= gray_d;
      len_q        <= len_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.gray = gray_q;
  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_gray_count_arbiter.sv
// tb/tb_gray_count_arbiter.sv - directed self-checking bench for gray_count_arbiter
module tb_gray_count_arbiter;

  logic clk;
  logic clear;
  int   checks;
  int   failures;

  gray_count_arbiter_if #(.WIDTH(4)) bus ();

  gray_count_arbiter #(.WIDTH(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // {gnt, done, busy, gray}
  wire [8:0] obs = {bus.gnt, bus.done, bus.busy, bus.gray};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    #2;
    clear    = 1'b0;
    bus.req  = 2'b00;
    bus.len0 = 4'd0;
    bus.len1 = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    clear = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.req  = 2'b11;
    bus.len0 = 4'd3;
    bus.len1 = 4'd3;
    clear    = 1'b1;
    #1;
    clear = 1'b0;
    #1;
    checks++;
    if (obs !== 9'h000) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs, 9'h000);
    end
    do_reset();
    checks++;
    if (obs !== 9'h000) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", obs, 9'h000);
    end
  endtask

  task automatic test_single_run;
    logic [3:0] exp_gray [4];
    logic [8:0] exp;
    exp_gray = '{4'h0, 4'h1, 4'h3, 4'h2};
    do_reset();
    bus.req  = 2'b01;
    bus.len0 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) bus.len0 = 4'd0;
      exp = {2'b01, 2'b00, 1'b1, exp_gray[i]};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL single_run_cycle%0d got=%h exp=%h", i, obs, exp);
      end
    end
    step();
    checks++;
    if (obs !== {2'b00, 2'b01, 1'b1, 4'h2}) begin
      failures++;
      $display("FAIL single_done got=%h exp=%h", obs, {2'b00, 2'b01, 1'b1, 4'h2});
    end
    bus.req = 2'b00;
    step();
    checks++;
    if (obs !== {2'b00, 2'b00, 1'b0, 4'h2}) begin
      failures++;
      $display("FAIL single_idle got=%h exp=%h", obs, {2'b00, 2'b00, 1'b0, 4'h2});
    end
  endtask

  task automatic test_contention;
    logic [1:0] g [3];
    logic [8:0] exp [4];
`ifdef GRAY_ARB_FIXED_PRIO_EN
    g = '{2'b01, 2'b01, 2'b01};
`else
    g = '{2'b01, 2'b10, 2'b01};
`endif
    do_reset();
    bus.req  = 2'b11;
    bus.len0 = 4'd1;
    bus.len1 = 4'd1;
    for (int k = 0; k < 3; k++) begin
      exp[0] = {g[k], 2'b00, 1'b1, 4'h0};
      exp[1] = {g[k], 2'b00, 1'b1, 4'h1};
      exp[2] = {2'b00, g[k], 1'b1, 4'h1};
      exp[3] = {2'b00, 2'b00, 1'b0, 4'h1};
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (obs !== exp[c]) begin
          failures++;
          $display("FAIL contention_grant%0d_cycle%0d got=%h exp=%h", k, c, obs, exp[c]);
        end
      end
    end
    bus.req = 2'b00;
    step();
  endtask

  task automatic test_max_len;
    logic [3:0] b;
    logic [8:0] exp;
    do_reset();
    bus.req  = 2'b01;
    bus.len0 = 4'd15;
    for (int i = 0; i < 16; i++) begin
      step();
      b   = i[3:0];
      exp = {2'b01, 2'b00, 1'b1, b ^ (b >> 1)};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL max_len_cycle%0d got=%h exp=%h", i, obs, exp);
      end
    end
    step();
    checks++;
    if (obs !== {2'b00, 2'b01, 1'b1, 4'h8}) begin
      failures++;
      $display("FAIL max_len_done got=%h exp=%h", obs, {2'b00, 2'b01, 1'b1, 4'h8});
    end
    bus.req = 2'b00;
    step();
    checks++;
    if (obs !== {2'b00, 2'b00, 1'b0, 4'h8}) begin
      failures++;
      $display("FAIL max_len_idle got=%h exp=%h", obs, {2'b00, 2'b00, 1'b0, 4'h8});
    end
  endtask

  task automatic test_abort;
    logic [3:0] exp_gray [3];
    logic [8:0] exp;
    exp_gray = '{4'h0, 4'h1, 4'h3};
    do_reset();
    bus.req  = 2'b10;
    bus.len1 = 4'd5;
    bus.len0 = 4'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) bus.req = 2'b11;
      exp = {2'b10, 2'b00, 1'b1, exp_gray[i]};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL abort_run_cycle%0d got=%h exp=%h", i, obs, exp);
      end
    end
    bus.req = 2'b01;
    step();
    checks++;
    if (obs !== {2'b00, 2'b00, 1'b0, 4'h3}) begin
      failures++;
      $display("FAIL abort_idle got=%h exp=%h", obs, {2'b00, 2'b00, 1'b0, 4'h3});
    end
    step();
    checks++;
    if (obs !== {2'b01, 2'b00, 1'b1, 4'h0}) begin
      failures++;
      $display("FAIL abort_regrant got=%h exp=%h", obs, {2'b01, 2'b00, 1'b1, 4'h0});
    end
    bus.req = 2'b00;
    step();
  endtask

  task automatic test_zero_len;
    do_reset();
    bus.req  = 2'b10;
    bus.len1 = 4'd0;
    step();
    checks++;
    if (obs !== {2'b10, 2'b00, 1'b1, 4'h0}) begin
      failures++;
      $display("FAIL zero_len_run got=%h exp=%h", obs, {2'b10, 2'b00, 1'b1, 4'h0});
    end
    step();
    checks++;
    if (obs !== {2'b00, 2'b10, 1'b1, 4'h0}) begin
      failures++;
      $display("FAIL zero_len_done got=%h exp=%h", obs, {2'b00, 2'b10, 1'b1, 4'h0});
    end
    step();
    bus.req = 2'b00;
    step();
    // Terminal count and abort in the same cycle: abort wins, no done pulse.
    bus.req  = 2'b01;
    bus.len0 = 4'd0;
    step();
    bus.req = 2'b00;
    step();
    checks++;
    if (obs !== {2'b00, 2'b00, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL abort_at_terminal got=%h exp=%h", obs, {2'b00, 2'b00, 1'b0, 4'h0});
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    bus.req  = 2'b01;
    bus.len0 = 4'd5;
    repeat (3) step();
    checks++;
    if (obs !== {2'b01, 2'b00, 1'b1, 4'h3}) begin
      failures++;
      $display("FAIL async_pre got=%h exp=%h", obs, {2'b01, 2'b00, 1'b1, 4'h3});
    end
    #2;
    clear = 1'b0;
    #1;
    checks++;
    if (obs !== 9'h000) begin
      failures++;
      $display("FAIL async_clear got=%h exp=%h", obs, 9'h000);
    end
    step();
    checks++;
    if (obs !== 9'h000) begin
      failures++;
      $display("FAIL async_held got=%h exp=%h", obs, 9'h000);
    end
    #3;
    clear    = 1'b1;
    bus.req  = 2'b11;
    bus.len0 = 4'd1;
    bus.len1 = 4'd1;
    step();
    checks++;
    if (obs !== {2'b01, 2'b00, 1'b1, 4'h0}) begin
      failures++;
      $display("FAIL async_first_grant got=%h exp=%h", obs, {2'b01, 2'b00, 1'b1, 4'h0});
    end
    bus.req = 2'b00;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear    = 1'b1;
    bus.req  = 2'b00;
    bus.len0 = 4'd0;
    bus.len1 = 4'd0;
    test_reset();
    test_single_run();
    test_contention();
    test_max_len();
    test_abort();
    test_zero_len();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_count_arbiter.md
GRAY_COUNT_ARBITER -- requirements
Module: gray_count_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the Gray counter width and the width of each run-length input.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 clear  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req  input  2  SHALL carry one level-sensitive request per requester (bit i = requester i).
REQ-005 len0  input  WIDTH  SHALL give requester 0's run length in Gray steps.
REQ-006 len1  input  WIDTH  SHALL give requester 1's run length in Gray steps.
REQ-007 gnt  output  2  SHALL be the one-hot-or-zero grant, registered.
REQ-008 gray  output  WIDTH  SHALL be the shared Gray counter value, registered.
REQ-009 done  output  2  SHALL carry a one-cycle completion pulse per requester.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-012 IDLE with req != 0 at edge t: RUN at t+1, gnt[i]=1 for the selected i, internal binary count=0, gray=0, len_q=len_i latched.
REQ-013 Selection SHALL be round-robin: if both request, grant the requester other than last_owner; if one requests, grant it.
REQ-014 last_owner SHALL update to the granted index on the IDLE->RUN edge.
REQ-015 In RUN with bin != len_q and req[owner]=1, bin SHALL increment by 1 per cycle, and gray SHALL equal bin ^ (bin >> 1) of the new bin.
REQ-016 In RUN with bin == len_q and req[owner]=1: next state DONE, gnt=0, done[owner]=1 for exactly that cycle, gray held.
REQ-017 DONE SHALL always go to IDLE on the next edge, with done=0; req is ignored in DONE.
REQ-018 gnt SHALL be high for exactly len_q+1 cycles on an unaborted run; len_q=0 gives one RUN cycle with gray=0.
REQ-019 len_q=2^WIDTH-1 SHALL run to gray = 1 followed by WIDTH-1 zeros with no wrap; bin SHALL never wrap inside a run.
REQ-020 Abort: in RUN, req[owner]=0 at an edge SHALL force IDLE next cycle, gnt=0, no done pulse, gray held; abort takes precedence over terminal count.
REQ-021 Changes on len0/len1 during RUN SHALL have no effect on the current run.
REQ-022 The non-owner's req SHALL have no effect until the FSM returns to IDLE; the minimum owner-to-owner gap SHALL be the DONE and IDLE cycles.
REQ-023 gnt SHALL never have both bits set; done SHALL never have both bits set.

Reset
REQ-024 clear=0 SHALL immediately, independent of clk, force state=IDLE, gnt=0, done=0, busy=0, gray=0, bin=0, len_q=0 and last_owner=1, so requester 0 wins the first contention.
REQ-025 Reset asserted mid-run SHALL abort the run with no done pulse; the first grant after release SHALL need a fresh IDLE sample.

Configuration
REQ-026 Macro GRAY_ARB_FIXED_PRIO_EN defined: selection SHALL be fixed priority, with requester 0 always winning contention; last_owner is unused.
REQ-027 Macro GRAY_ARB_FIXED_PRIO_EN undefined (default): round-robin selection per REQ-013.

Verification
REQ-028 Reset then req=01, len0=3: gnt=01 for 4 cycles, gray 0,1,3,2, then done=01 for 1 cycle, busy falls after DONE.
REQ-029 req=11 held continuously, len0=len1=1: grants alternate 01,10,01; each gnt lasts 2 cycles, with a 2-cycle gap (DONE and IDLE) between grants.
REQ-030 req=01, len0=15: gray ends at 1000 after 16 grant cycles, with no wrap, and done=01.
REQ-031 req=10, len1=5; drop req[1] after 2 RUN cycles: gnt=00 next cycle, done stays 00, gray held at 11.
REQ-032 Pull clear low mid-run between clock edges: all outputs are 0 immediately; after release, req=11 grants 01 first.
REQ-033 With GRAY_ARB_FIXED_PRIO_EN defined and req=11 held: every grant is 01.
